// File: rtl/hls_loop_engine.sv
// Loop kernel: scans k RAM words from base v, reduces accepted words (sum or max,
// word <= THRESH) and counts rejects, then writes both results back and reports done.
module hls_loop_engine #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int THRESH   = 100,
    parameter int OUT_ADDR = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] v,
    input  logic [ADDR_W:0]   k,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] rej_cnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata
);

    typedef enum logic [2:0] {IDLE, RD, ACC, WR0, WR1, DONE} state_t;

    localparam logic [DATA_W-1:0] THRESH_V = DATA_W'(THRESH);
    localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);
    localparam logic [ADDR_W:0]   IDX_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] OUT_A0   = ADDR_W'(OUT_ADDR);
    localparam logic [ADDR_W-1:0] OUT_A1   = ADDR_W'(OUT_ADDR + 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   trip;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   idx_inc;
    logic              mode_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] rej;
    logic              accept;

    assign idx_inc = idx + IDX_ONE;
    assign accept  = (mem_rdata <= THRESH_V);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = (k != '0) ? RD : WR0;
            end
            RD: begin
                mem_re     = 1'b1;
                mem_addr   = base + idx[ADDR_W-1:0];
                state_next = ACC;
            end
            ACC: state_next = (idx_inc < trip) ? RD : WR0;
            WR0: begin
                mem_we     = 1'b1;
                mem_addr   = OUT_A0;
                mem_wdata  = acc;
                state_next = WR1;
            end
            WR1: begin
                mem_we     = 1'b1;
                mem_addr   = OUT_A1;
                mem_wdata  = rej;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured at launch, so input changes mid-run are invisible.
    always_ff @(posedge clk) begin
        if (reset) begin
            base    <= '0;
            trip    <= '0;
            idx     <= '0;
            mode_q  <= 1'b0;
            acc     <= '0;
            rej     <= '0;
            result  <= '0;
            rej_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base   <= v;
                        trip   <= k;
                        mode_q <= mode;
                        idx    <= '0;
                        acc    <= '0;
                        rej    <= '0;
                    end
                end
                ACC: begin
                    if (accept) begin
                        if (mode_q) acc <= (mem_rdata > acc) ? mem_rdata : acc;
                        else        acc <= acc + mem_rdata;
                    end else if (rej != '1) begin
                        rej <= rej + DATA_ONE;
                    end
                    idx <= idx_inc;
                end
                WR1: begin
                    // Published on entry to DONE so they are valid alongside done.
                    result  <= acc;
                    rej_cnt <= rej;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hls_loop_engine.sv
// Self-checking bench for hls_loop_engine: table vectors, start-hold and reset
// corner cases, and randomized runs against a RAM-snapshot reference model.
module tb_hls_loop_engine;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int OUT = 1000;
    localparam int TH  = 100;

    logic          clk;
    logic          reset;
    logic          start;
    logic          mode;
    logic [AW-1:0] v;
    logic [AW:0]   k;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic [DW-1:0] rej_cnt;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;

    hls_loop_engine #(.DATA_W(DW), .ADDR_W(AW), .THRESH(TH), .OUT_ADDR(OUT)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .v(v), .k(k),
        .busy(busy), .done(done), .result(result), .rej_cnt(rej_cnt),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM; strobes are sampled mid-cycle to stay clear of the edge.
    logic [DW-1:0] ram [0:1023];
    logic          re_s, we_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] wdata_s;
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    int            rd_q[$];
    int            wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            bad_cnt;
    int            checks;
    int            failures;

    always @(negedge clk) begin
        re_s    = mem_re;
        we_s    = mem_we;
        addr_s  = mem_addr;
        wdata_s = mem_wdata;
        if (mem_re) rd_q.push_back(int'(mem_addr));
        if (mem_we) begin
            wa_q.push_back(int'(mem_addr));
            wd_q.push_back(mem_wdata);
        end
        if ((mem_re && mem_we) || (!busy && (mem_re || mem_we))) bad_cnt++;
    end

    always @(posedge clk) begin
        if (re_s) mem_rdata <= ram[addr_s];
        if (we_s) ram[addr_s] <= wdata_s;
        else if (pl_en) ram[pl_addr] <= pl_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic poke(input int a, input logic [DW-1:0] d);
        pl_addr = AW'(a);
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Reference: walk the window over the pre-run RAM contents.
    function automatic void model(input bit m, input int vv, input int kk,
                                  output logic [DW-1:0] r, output logic [DW-1:0] rj);
        logic [DW-1:0] a;
        r  = '0;
        rj = '0;
        for (int j = 0; j < kk; j++) begin
            a = ram[(vv + j) % 1024];
            if (a <= TH) r = m ? ((a > r) ? a : r) : r + a;
            else if (rj != '1) rj = rj + 1;
        end
    endfunction

    task automatic run_check(input string nm, input bit m, input int vv, input int kk,
                             input logic [DW-1:0] er, input logic [DW-1:0] ej);
        int n, r0, w0, b0;
        bit seen;
        r0 = rd_q.size();
        w0 = wa_q.size();
        b0 = bad_cnt;
        @(negedge clk);
        start = 1'b1; mode = m; v = AW'(vv); k = (AW+1)'(kk);
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 2*kk + 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                mode  = 1'($urandom);
                v     = AW'($urandom);
                k     = (AW+1)'($urandom);
            end
            seen = done;
        end
        check({nm, ".latency"}, seen ? n : -1, 2*kk + 3);
        check({nm, ".result"}, result, er);
        check({nm, ".rej_cnt"}, rej_cnt, ej);
        check({nm, ".reads"}, rd_q.size() - r0, kk);
        for (int j = 0; j < kk; j++)
            if (r0 + j < rd_q.size())
                check($sformatf("%s.rd_addr%0d", nm, j), rd_q[r0 + j], (vv + j) % 1024);
        check({nm, ".writes"}, wa_q.size() - w0, 2);
        if (wa_q.size() - w0 >= 2) begin
            check({nm, ".wr0_addr"}, wa_q[w0], OUT);
            check({nm, ".wr0_data"}, wd_q[w0], er);
            check({nm, ".wr1_addr"}, wa_q[w0 + 1], (OUT + 1) % 1024);
            check({nm, ".wr1_data"}, wd_q[w0 + 1], ej);
        end
        check({nm, ".ram_out0"}, ram[OUT], er);
        check({nm, ".ram_out1"}, ram[(OUT + 1) % 1024], ej);
        check({nm, ".strobes"}, bad_cnt - b0, 0);
    endtask

    typedef struct {
        bit mode;
        int v;
        int k;
        int d0, d1, d2, d3;
        int exp_res;
        int exp_rej;
    } vec_t;

    initial begin
        vec_t          tbl[8];
        logic [DW-1:0] er, ej, er2, ej2, pre;
        int            n, w0, rm, rv, rk;
        bit            seen;

        tbl[0] = '{1'b0,    0, 4,   5, 150, 100,    7, 112, 1};
        tbl[1] = '{1'b1,    0, 4,   5, 150, 100,    7, 100, 1};
        tbl[2] = '{1'b0,   17, 0,   0,   0,   0,    0,   0, 0};
        tbl[3] = '{1'b0, 1022, 3,   1,   2,   3,    0,   6, 0};
        tbl[4] = '{1'b1,    8, 4, 200, 300, 101, 1000,   0, 4};
        tbl[5] = '{1'b0,   40, 4, 100, 101,   0,  100, 200, 1};
        tbl[6] = '{1'b1,   60, 4,  99, 100, 101,   50, 100, 1};
        tbl[7] = '{1'b0,  998, 4,  50,  60,  70,   80, 260, 0};

        checks = 0; failures = 0; bad_cnt = 0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        reset = 1'b1; start = 1'b0; mode = 1'b0; v = '0; k = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.result", result, 0);
        check("reset.rej_cnt", rej_cnt, 0);
        check("reset.mem_bus", {mem_re, mem_we, mem_addr, mem_wdata}, 0);
        reset = 1'b0;

        for (int a = 0; a < 1024; a++)
            poke(a, ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 150)));

        foreach (tbl[i]) begin
            if (tbl[i].k > 0) begin
                poke((tbl[i].v + 0) % 1024, DW'(tbl[i].d0));
                poke((tbl[i].v + 1) % 1024, DW'(tbl[i].d1));
                poke((tbl[i].v + 2) % 1024, DW'(tbl[i].d2));
                poke((tbl[i].v + 3) % 1024, DW'(tbl[i].d3));
            end
            run_check($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].v, tbl[i].k,
                      DW'(tbl[i].exp_res), DW'(tbl[i].exp_rej));
        end

        // start held high: one run per IDLE visit, relaunch right after DONE.
        poke(0, 5); poke(1, 150); poke(2, 100); poke(3, 7);
        @(negedge clk);
        start = 1'b1; mode = 1'b0; v = '0; k = 11'd4;
        @(posedge clk);
        n = 0; seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (n == 1) begin v = 10'd500; k = 11'd5; mode = 1'b1; end
            seen = done;
        end
        check("hold.lat1", seen ? n : -1, 11);
        check("hold.result1", result, 112);
        check("hold.rej1", rej_cnt, 1);
        model(1'b1, 500, 5, er2, ej2);
        @(negedge clk);
        check("hold.idle_gap", busy, 0);
        @(negedge clk);
        check("hold.restart", busy, 1);
        start = 1'b0; v = 10'd7; k = '0; mode = 1'b0;
        n = 1; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 4) start = 1'b1;
            if (n == 6) start = 1'b0;
            seen = done;
        end
        check("hold.lat2", seen ? n : -1, 13);
        check("hold.result2", result, er2);
        check("hold.rej2", rej_cnt, ej2);
        repeat (10) @(negedge clk);
        check("hold.no_queue", busy, 0);

        // Reset during the second ACC must abort with no write-back.
        poke(0, 5); poke(1, 150); poke(2, 100); poke(3, 7);
        pre = ram[OUT];
        w0 = wa_q.size();
        @(negedge clk);
        start = 1'b1; mode = 1'b0; v = '0; k = 11'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.result", result, 0);
        check("rst.rej_cnt", rej_cnt, 0);
        check("rst.mem_bus", {mem_re, mem_we, mem_addr, mem_wdata}, 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("rst.no_writes", wa_q.size() - w0, 0);
        check("rst.ram_out0", ram[OUT], pre);
        run_check("after_rst", 1'b0, 0, 4, 112, 1);

        for (int t = 0; t < 30; t++) begin
            rm = int'($urandom_range(0, 1));
            rv = int'($urandom_range(0, 1023));
            rk = (t % 10 == 0) ? 1 : int'($urandom_range(0, 12));
            model(rm[0], rv, rk, er, ej);
            run_check($sformatf("rnd%0d", t), rm[0], rv, rk, er, ej);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
